cnn_layer_sequencer: RTL and testbench

Control-path sequencer for the CNN feature extractor. It runs the shared convolution/pooling engine through every layer in order: 2×NUM_BLOCKS convolution layers (expansion and depthwise, alternating), then one 2×2/stride-2 pooling layer. It issues one row command at a time over a valid/ready handshake, selects the ping-pong source buffer, and includes a per-row watchdog. It sits between the image-size detector, which produces `size_detection_done` and `image_size`, and the compute engine.

---
 rtl/cnn_layer_sequencer_pkg.sv | 18 +
 rtl/cnn_layer_sequencer_if.sv | 23 ++
 rtl/cnn_layer_sequencer_watchdog.sv | 27 ++
 rtl/cnn_layer_sequencer.sv | 114 +++++++++++
 tb/tb_cnn_layer_sequencer.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_layer_sequencer_pkg.sv
// Shared types for the CNN layer sequencer: engine op codes and FSM states.
package cnn_pkg;
  localparam int CNN_OP_W = 2;

  typedef enum logic [CNN_OP_W-1:0] {
    EXPAND    = 2'd0,
    DEPTHWISE = 2'd1,
    POOL      = 2'd2
  } cnn_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_ERROR
  } seq_state_e;
endpackage

// File: rtl/cnn_layer_sequencer_if.sv
// Row-command channel between the sequencer (master) and the compute engine (slave).
interface cnn_layer_sequencer_if import cnn_pkg::*; #(
  parameter int LAYER_W = 4,
  parameter int ROW_W   = 10
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [LAYER_W-1:0]  cmd_layer;
  logic [CNN_OP_W-1:0] cmd_op;
  logic [ROW_W-1:0]    cmd_row;
  logic                cmd_src_buf;
  logic                row_done;

  modport master (
    output cmd_valid, cmd_layer, cmd_op, cmd_row, cmd_src_buf,
    input  cmd_ready, row_done
  );

  modport slave (
    input  cmd_valid, cmd_layer, cmd_op, cmd_row, cmd_src_buf,
    output cmd_ready, row_done
  );
endinterface

// File: rtl/cnn_layer_sequencer_watchdog.sv
// Per-row watchdog: counts while enabled, held at zero while cleared, flags expiry.
module cnn_watchdog #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q >= CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    cnt_d = cnt_q;
    if (clear)                 cnt_d = '0;
    else if (enable && !expired) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/cnn_layer_sequencer.sv
// Walks the conv/pool engine through every layer, one row command at a time,
// alternating ping-pong source buffers per layer and guarding each row with a watchdog.
module cnn_layer_sequencer import cnn_pkg::*; #(
  parameter int NUM_BLOCKS          = 5,
  parameter int MAX_IMAGE_SIZE_LOG2 = 9,
  parameter int TIMEOUT_CYCLES      = 65535,
  parameter int LAYER_W             = $clog2(2*NUM_BLOCKS+1)
) (
  input  logic                         data_clk,
  input  logic                         rst,
  input  logic                         size_detection_done,
  input  logic [MAX_IMAGE_SIZE_LOG2:0] image_size,
  cnn_layer_sequencer_if.master        cmd,
  output logic                         busy,
  output logic                         seq_done,
  output logic                         error
);
  localparam int ROW_W = MAX_IMAGE_SIZE_LOG2 + 1;
  localparam int SUM_W = ROW_W + 1;
  localparam logic [LAYER_W-1:0] POOL_LAYER = LAYER_W'(2*NUM_BLOCKS);
  localparam logic [ROW_W-1:0]   MAX_SIZE   = ROW_W'(1 << MAX_IMAGE_SIZE_LOG2);

  seq_state_e         state_q, state_d;
  logic               sd_q, sd_d;
  logic [ROW_W-1:0]   sz_q, sz_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic               buf_q, buf_d;
  logic [SUM_W-1:0]   row_nxt;
  logic               wd_expired;

  cnn_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk     (data_clk),
    .rst     (rst),
    .clear   (state_q != S_WAIT),
    .enable  (state_q == S_WAIT),
    .expired (wd_expired)
  );

  always_comb begin
    state_d = state_q;
    sd_d    = size_detection_done;
    sz_d    = sz_q;
    layer_d = layer_q;
    row_d   = row_q;
    buf_d   = buf_q;
    // One bit wider than the row so the pool stride past the last row cannot wrap.
    row_nxt = {1'b0, row_q} + ((layer_q == POOL_LAYER) ? SUM_W'(2) : SUM_W'(1));
    unique case (state_q)
      S_IDLE: if (size_detection_done && !sd_q) begin
        sz_d = image_size;
        if (image_size == '0 || image_size > MAX_SIZE) begin
          state_d = S_ERROR;
        end else begin
          layer_d = '0;
          row_d   = '0;
          buf_d   = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: if (cmd.cmd_ready) state_d = S_WAIT;
      S_WAIT: begin
        if (cmd.row_done) begin
          if (row_nxt < {1'b0, sz_q}) begin
            row_d   = row_nxt[ROW_W-1:0];
            state_d = S_ISSUE;
          end else if (layer_q == POOL_LAYER) begin
            row_d   = '0;
            layer_d = '0;
            buf_d   = 1'b0;
            state_d = S_DONE;
          end else begin
            row_d   = '0;
            layer_d = layer_q + 1'b1;
            buf_d   = ~buf_q;
            state_d = S_ISSUE;
          end
        end else if (wd_expired) begin
          state_d = S_ERROR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge data_clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sd_q    <= 1'b0;
      sz_q    <= '0;
      layer_q <= '0;
      row_q   <= '0;
      buf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sd_q    <= sd_d;
      sz_q    <= sz_d;
      layer_q <= layer_d;
      row_q   <= row_d;
      buf_q   <= buf_d;
    end
  end

  assign cmd.cmd_valid   = (state_q == S_ISSUE);
  assign cmd.cmd_layer   = layer_q;
  assign cmd.cmd_row     = row_q;
  assign cmd.cmd_src_buf = buf_q;
  assign cmd.cmd_op      = (layer_q == POOL_LAYER) ? POOL : (layer_q[0] ? DEPTHWISE : EXPAND);
  assign busy            = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_DONE);
  assign seq_done        = (state_q == S_DONE);
  assign error           = (state_q == S_ERROR);
endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed bench for cnn_layer_sequencer: table of expected row commands plus corner sequences.
module tb_cnn_layer_sequencer;
  import cnn_pkg::*;

  localparam int NB   = 1;
  localparam int LOG2 = 9;
  localparam int TO   = 8;
  localparam int LW   = $clog2(2*NB+1);
  localparam int RW   = LOG2 + 1;

  logic          data_clk = 1'b0;
  logic          rst;
  logic          sdd;
  logic [RW-1:0] image_size;
  logic          busy, seq_done, error;

  cnn_layer_sequencer_if #(.LAYER_W(LW), .ROW_W(RW)) cmd_bus ();

  cnn_layer_sequencer #(
    .NUM_BLOCKS(NB), .MAX_IMAGE_SIZE_LOG2(LOG2), .TIMEOUT_CYCLES(TO), .LAYER_W(LW)
  ) dut (
    .data_clk            (data_clk),
    .rst                 (rst),
    .size_detection_done (sdd),
    .image_size          (image_size),
    .cmd                 (cmd_bus),
    .busy                (busy),
    .seq_done            (seq_done),
    .error               (error)
  );

  always #5 data_clk = ~data_clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit first;
    bit last;
    int sz;
    int layer;
    int op;
    int row;
    int bsel;
  } vec_t;

  vec_t vec[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input bit f, input bit l, input int sz, input int ly, input int op,
                     input int r, input int b);
    vec_t v;
    v.first = f; v.last = l; v.sz = sz; v.layer = ly; v.op = op; v.row = r; v.bsel = b;
    vec.push_back(v);
  endtask

  // Called at a negedge; leaves the bench at the negedge of the cycle after the edge.
  task automatic start(input int sz);
    sdd = 1'b1;
    image_size = RW'(sz);
    @(negedge data_clk);
    sdd = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (cmd_bus.cmd_valid !== 1'b1 && n < 20) begin
      @(negedge data_clk);
      n++;
    end
    chk("cmd_valid_wait", cmd_bus.cmd_valid, 1);
  endtask

  task automatic serve_one();
    wait_valid();
    @(negedge data_clk);
    @(negedge data_clk);
    cmd_bus.row_done = 1'b1;
    @(negedge data_clk);
    cmd_bus.row_done = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge data_clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1; sdd = 1'b0; image_size = '0;
    cmd_bus.cmd_ready = 1'b1;
    cmd_bus.row_done  = 1'b0;

    // size 4: 4 expand rows, 4 depthwise rows, pool rows 0 and 2
    add(1,0,4, 0,0,0,0); add(0,0,4, 0,0,1,0); add(0,0,4, 0,0,2,0); add(0,0,4, 0,0,3,0);
    add(0,0,4, 1,1,0,1); add(0,0,4, 1,1,1,1); add(0,0,4, 1,1,2,1); add(0,0,4, 1,1,3,1);
    add(0,0,4, 2,2,0,0); add(0,1,4, 2,2,2,0);
    // size 5: odd edge, pool rows 0,2,4
    add(1,0,5, 0,0,0,0); add(0,0,5, 0,0,1,0); add(0,0,5, 0,0,2,0); add(0,0,5, 0,0,3,0);
    add(0,0,5, 0,0,4,0);
    add(0,0,5, 1,1,0,1); add(0,0,5, 1,1,1,1); add(0,0,5, 1,1,2,1); add(0,0,5, 1,1,3,1);
    add(0,0,5, 1,1,4,1);
    add(0,0,5, 2,2,0,0); add(0,0,5, 2,2,2,0); add(0,1,5, 2,2,4,0);
    // size 1: single row per layer
    add(1,0,1, 0,0,0,0); add(0,0,1, 1,1,0,1); add(0,1,1, 2,2,0,0);

    #2;
    chk("rst_valid", cmd_bus.cmd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_seq_done", seq_done, 0);
    chk("rst_error", error, 0);
    chk("rst_fields", {cmd_bus.cmd_layer, cmd_bus.cmd_op, cmd_bus.cmd_row, cmd_bus.cmd_src_buf}, 0);
    @(negedge data_clk);
    rst = 1'b0;
    @(negedge data_clk);

    for (int i = 0; i < vec.size(); i++) begin
      if (vec[i].first) start(vec[i].sz);
      wait_valid();
      chk($sformatf("v%0d_busy", i), busy, 1);
      chk($sformatf("v%0d_layer", i), cmd_bus.cmd_layer, vec[i].layer);
      chk($sformatf("v%0d_op", i), cmd_bus.cmd_op, vec[i].op);
      chk($sformatf("v%0d_row", i), cmd_bus.cmd_row, vec[i].row);
      chk($sformatf("v%0d_buf", i), cmd_bus.cmd_src_buf, vec[i].bsel);
      @(negedge data_clk);
      chk($sformatf("v%0d_valid_drop", i), cmd_bus.cmd_valid, 0);
      @(negedge data_clk);
      cmd_bus.row_done = 1'b1;
      @(negedge data_clk);
      cmd_bus.row_done = 1'b0;
      if (vec[i].last) begin
        chk($sformatf("v%0d_seq_done", i), seq_done, 1);
        chk($sformatf("v%0d_done_busy", i), busy, 1);
        @(negedge data_clk);
        chk($sformatf("v%0d_seq_done_end", i), seq_done, 0);
        chk($sformatf("v%0d_busy_end", i), busy, 0);
      end else begin
        chk($sformatf("v%0d_next_valid", i), cmd_bus.cmd_valid, 1);
      end
    end

    // Backpressure: fields stable and watchdog idle while stalled in ISSUE.
    cmd_bus.cmd_ready = 1'b0;
    start(2);
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("bp%0d_valid", k), cmd_bus.cmd_valid, 1);
      chk($sformatf("bp%0d_fields", k),
          {cmd_bus.cmd_layer, cmd_bus.cmd_op, cmd_bus.cmd_row, cmd_bus.cmd_src_buf}, 0);
      @(negedge data_clk);
    end
    cmd_bus.cmd_ready = 1'b1;
    @(negedge data_clk);
    chk("bp_wait_valid", cmd_bus.cmd_valid, 0);
    repeat (7) @(negedge data_clk);
    cmd_bus.row_done = 1'b1;
    @(negedge data_clk);
    cmd_bus.row_done = 1'b0;
    chk("bp_late_row_error", error, 0);
    chk("bp_next_valid", cmd_bus.cmd_valid, 1);
    chk("bp_next_row", cmd_bus.cmd_row, 1);

    // Timeout: row_done withheld after the row-1 handshake.
    @(negedge data_clk);
    repeat (8) @(negedge data_clk);
    chk("to_error_before", error, 0);
    chk("to_busy_before", busy, 1);
    @(negedge data_clk);
    chk("to_error", error, 1);
    chk("to_busy", busy, 0);
    chk("to_valid", cmd_bus.cmd_valid, 0);
    repeat (3) @(negedge data_clk);
    chk("to_error_sticky", error, 1);
    chk("to_busy_stays", busy, 0);
    pulse_rst();
    chk("to_rst_clears", error, 0);

    // Illegal size 0, then a further start must be ignored.
    start(0);
    chk("sz0_error", error, 1);
    chk("sz0_valid", cmd_bus.cmd_valid, 0);
    chk("sz0_busy", busy, 0);
    @(negedge data_clk);
    start(4);
    repeat (3) begin
      chk("sz0_restart_valid", cmd_bus.cmd_valid, 0);
      chk("sz0_restart_error", error, 1);
      @(negedge data_clk);
    end
    pulse_rst();

    start(513);
    chk("sz513_error", error, 1);
    chk("sz513_valid", cmd_bus.cmd_valid, 0);
    pulse_rst();

    start(512);
    chk("sz512_error", error, 0);
    chk("sz512_valid", cmd_bus.cmd_valid, 1);
    pulse_rst();

    // Reset while waiting on L1 row 1, then restart from scratch.
    start(4);
    repeat (5) serve_one();
    chk("mid_layer", cmd_bus.cmd_layer, 1);
    chk("mid_row", cmd_bus.cmd_row, 1);
    chk("mid_buf", cmd_bus.cmd_src_buf, 1);
    @(negedge data_clk);
    chk("mid_in_wait", cmd_bus.cmd_valid, 0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", cmd_bus.cmd_valid, 0);
    chk("mid_rst_seq_error", {seq_done, error}, 0);
    chk("mid_rst_fields",
        {cmd_bus.cmd_layer, cmd_bus.cmd_op, cmd_bus.cmd_row, cmd_bus.cmd_src_buf}, 0);
    @(negedge data_clk);
    rst = 1'b0;
    start(4);
    chk("restart_valid", cmd_bus.cmd_valid, 1);
    chk("restart_fields",
        {cmd_bus.cmd_layer, cmd_bus.cmd_op, cmd_bus.cmd_row, cmd_bus.cmd_src_buf}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
